// File: rtl/gate_chk_pkg.sv
// Shared types, vector encodings and the reference gate function for gate_vector_checker.
package gate_chk_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned VEC_W  = 2;
  localparam int unsigned PASS_W = 4;
  localparam int unsigned ERR_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [VEC_W-1:0] VEC_00 = 2'b00;
  localparam logic [VEC_W-1:0] VEC_01 = 2'b01;
  localparam logic [VEC_W-1:0] VEC_10 = 2'b10;
  localparam logic [VEC_W-1:0] VEC_11 = 2'b11;

  localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

  // Snapshot of the first failing sample in a run.
  typedef struct packed {
    logic [VEC_W-1:0] vec;
    logic [1:0]       c;
  } fail_rec_t;

  // Expected gate result: bit 1 = NOR, bit 0 = NAND.
  function automatic logic [1:0] exp_c(input logic a, input logic b);
    return {~(a | b), ~(a & b)};
  endfunction

endpackage

// File: rtl/gate_vector_checker_gate_dwell_timer.sv
// Dwell counter: counts enabled cycles and flags the last cycle of each DWELL-long window.
module gate_dwell_timer
  import gate_chk_pkg::*;
#(
  parameter int unsigned DWELL = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_c = (cnt_q == CNT_W'(DWELL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gate_vector_checker.sv
// Self-running truth-table sweep and checker for a NAND/NOR gate pair.
// Optional first-failure capture ports enabled by GATE_CHK_FIRST_FAIL_EN.
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned DWELL      = 20,
  parameter int unsigned NUM_PASSES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic [1:0]       c_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] vec_idx
`ifdef GATE_CHK_FIRST_FAIL_EN
  ,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec,
  output logic [1:0]       fail_c
`endif
);

  state_e            state_q, state_d;
  logic              start_acc;
  logic              tc;
  logic              sample;
  logic              mismatch;
  logic              last_pass;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  gate_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_acc),
    .en_i  (state_q == DRIVE),
    .tc_c  (tc)
  );

  assign last_pass = (pass_cnt_q == PASS_W'(NUM_PASSES - 1));
  assign sample    = (state_q == DRIVE) && tc;
  assign mismatch  = sample && (c_in != exp_c(vec_q[1], vec_q[0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; start is only honoured outside DRIVE.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = DRIVE;
          start_acc = 1'b1;
        end
      end
      DRIVE: begin
        if (tc && (vec_q == VEC_11) && last_pass) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values and registered status outputs.
  always_comb begin
    vec_d      = vec_q;
    pass_cnt_d = pass_cnt_q;
    err_d      = err_q;
    if (start_acc) begin
      vec_d      = VEC_00;
      pass_cnt_d = '0;
      err_d      = '0;
    end else if (sample) begin
      if (mismatch && (err_q != ERR_MAX)) err_d = err_q + ERR_W'(1);
      if (vec_q != VEC_11) begin
        vec_d = vec_q + VEC_W'(1);
      end else if (!last_pass) begin
        vec_d      = VEC_00;
        pass_cnt_d = pass_cnt_q + PASS_W'(1);
      end
    end
    busy_d = (state_d == DRIVE);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q      <= VEC_00;
      pass_cnt_q <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      vec_q      <= vec_d;
      pass_cnt_q <= pass_cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign a         = vec_q[1];
  assign b         = vec_q[0];
  assign vec_idx   = vec_q;
  assign err_count = err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic      fail_vld_q, fail_vld_d;
  fail_rec_t fail_q, fail_d;

  always_comb begin
    fail_vld_d = fail_vld_q;
    fail_d     = fail_q;
    if (start_acc) begin
      fail_vld_d = 1'b0;
      fail_d     = '0;
    end else if (mismatch && !fail_vld_q) begin
      fail_vld_d = 1'b1;
      fail_d     = '{vec: vec_q, c: c_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_vld_q <= 1'b0;
      fail_q     <= '0;
    end else begin
      fail_vld_q <= fail_vld_d;
      fail_q     <= fail_d;
    end
  end

  assign fail_valid = fail_vld_q;
  assign fail_vec   = fail_q.vec;
  assign fail_c     = fail_q.c;
`endif

endmodule
